// File: rtl/nios_debug_slave_cmd_sync.sv
// System-clock stage of the debug slave: synchronises virtual-JTAG update events,
// captures scan data into a valid/ready command and emits per-instruction strobes.
`timescale 1ns/1ps
module nios_debug_slave_cmd_sync #(
    parameter int  IR_WIDTH    = 2,
    parameter int  SR_WIDTH    = 38,
    parameter int  ACTION_BIT  = 35,
    parameter int  SYNC_STAGES = 2,
    localparam int NUM_IR      = 2 ** IR_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vs_uir,
    input  logic                vs_udr,
    input  logic [IR_WIDTH-1:0] ir_in,
    input  logic [SR_WIDTH-1:0] sr,
    input  logic                cmd_ready,
    input  logic                ovf_clr,
    output logic                cmd_valid,
    output logic [IR_WIDTH-1:0] cmd_ir,
    output logic                cmd_action,
    output logic [SR_WIDTH-1:0] jdo,
    output logic [NUM_IR-1:0]   take_action,
    output logic [NUM_IR-1:0]   take_no_action,
    output logic                ovf
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be in 2..4");
    end
    if (ACTION_BIT >= SR_WIDTH) begin : g_bad_action_bit
        $error("ACTION_BIT must be below SR_WIDTH");
    end

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q;
    logic                   uir_dly_q, udr_dly_q;
    logic [IR_WIDTH-1:0]    ir_reg_q, ir_reg_d;
    logic [IR_WIDTH-1:0]    cmd_ir_q, cmd_ir_d;
    logic                   cmd_action_q, cmd_action_d;
    logic [SR_WIDTH-1:0]    jdo_q, jdo_d;
    logic                   ovf_q, ovf_d;
    logic                   uir_evt, udr_evt, accept, load, drop;

    // Bit 0 is the first flop; the delay flop trails the last stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            uir_dly_q  <= 1'b0;
            udr_dly_q  <= 1'b0;
        end else begin
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            uir_dly_q  <= uir_sync_q[SYNC_STAGES-1];
            udr_dly_q  <= udr_sync_q[SYNC_STAGES-1];
        end
    end

    assign uir_evt = uir_sync_q[SYNC_STAGES-1] & ~uir_dly_q;
    assign udr_evt = udr_sync_q[SYNC_STAGES-1] & ~udr_dly_q;
    // Reset in the same cycle discards the pending command without a strobe.
    assign accept  = (state_q == PEND) && cmd_ready && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ir_reg_q     <= '0;
            cmd_ir_q     <= '0;
            cmd_action_q <= 1'b0;
            jdo_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_reg_q     <= ir_reg_d;
            cmd_ir_q     <= cmd_ir_d;
            cmd_action_q <= cmd_action_d;
            jdo_q        <= jdo_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ir_reg_d     = ir_reg_q;
        cmd_ir_d     = cmd_ir_q;
        cmd_action_d = cmd_action_q;
        jdo_d        = jdo_q;
        load         = 1'b0;
        drop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (udr_evt) begin
                    load    = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (accept) begin
                    if (udr_evt) load = 1'b1;
                    else         state_d = IDLE;
                end else if (udr_evt) begin
                    drop = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A simultaneous uir event only affects later commands.
        if (load) begin
            jdo_d        = sr;
            cmd_ir_d     = ir_reg_q;
            cmd_action_d = sr[ACTION_BIT];
        end
        if (uir_evt) ir_reg_d = ir_in;

        ovf_d = drop | (ovf_q & ~ovf_clr);
    end

    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        if (accept) begin
            if (cmd_action_q) take_action[cmd_ir_q]    = 1'b1;
            else              take_no_action[cmd_ir_q] = 1'b1;
        end
    end

    assign cmd_valid  = (state_q == PEND);
    assign cmd_ir     = cmd_ir_q;
    assign cmd_action = cmd_action_q;
    assign jdo        = jdo_q;
    assign ovf        = ovf_q;

endmodule
